// File: rtl/wb_line_fetch.sv
// rtl/wb_line_fetch.sv - Wishbone read-only line fetch engine with show-ahead FIFO (optional ack watchdog: WB_FETCH_TIMEOUT_EN)
module wb_line_fetch #(
    parameter int WB_ADDR_WIDTH  = 24,
    parameter int WB_DATA_WIDTH  = 16,
    parameter int LEN_WIDTH      = 10,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           start_i,
    input  logic [WB_ADDR_WIDTH-1:0]       base_adr_i,
    input  logic [LEN_WIDTH-1:0]           len_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic                           wb_cyc_o,
    output logic                           wb_stb_o,
    output logic                           wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0]       wb_adr_o,
    output logic [WB_DATA_WIDTH/8-1:0]     wb_sel_o,
    input  logic [WB_DATA_WIDTH-1:0]       wb_dat_i,
    input  logic                           wb_ack_i,
    input  logic                           fifo_rd_i,
    output logic [WB_DATA_WIDTH-1:0]       fifo_dat_o,
    output logic                           fifo_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_LV = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic                       stb_q, stb_d;
    logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [LEN_WIDTH-1:0]       rem_q, rem_d;

    logic [WB_DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]              level_q;

    logic                       fifo_space;
    logic                       push;
    logic                       pop;
    logic                       tmo_hit;

    // One request in flight at most, so free space only has to account for stored words.
    assign fifo_space = (level_q < DEPTH_LV);
    assign push       = stb_q && wb_ack_i;
    assign pop        = fifo_rd_i && (level_q != '0);

`ifdef WB_FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q;
    logic          err_q, err_d;

    assign tmo_hit = stb_q && !wb_ack_i && (tmo_q == TMO_LAST);

    // Watchdog counts strobe cycles of the current request; restarts whenever strobe is low.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !stb_q || wb_ack_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Sticky error: set by a watchdog expiry, cleared by the next accepted start.
    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start_i) begin
            err_d = 1'b0;
        end else if (tmo_hit) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Next-state and bus request logic; strobe is only raised when the FIFO can take the word.
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        adr_d   = base_adr_i;
                        rem_d   = len_i;
                        stb_d   = fifo_space;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (stb_q) begin
                    if (wb_ack_i) begin
                        stb_d   = 1'b0;
                        adr_d   = adr_q + WB_ADDR_WIDTH'(1);
                        rem_d   = rem_q - LEN_WIDTH'(1);
                        state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_GAP;
                    end else if (tmo_hit) begin
                        stb_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end else begin
                    stb_d = fifo_space;
                end
            end
            S_GAP: begin
                stb_d   = fifo_space;
                state_d = S_REQ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state and registered Wishbone outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            stb_q   <= 1'b0;
            adr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave the level unchanged.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wb_dat_i;
        end
    end

    assign busy_o       = (state_q == S_REQ) || (state_q == S_GAP);
    assign done_o       = (state_q == S_DONE);
    assign wb_cyc_o     = stb_q;
    assign wb_stb_o     = stb_q;
    assign wb_we_o      = 1'b0;
    assign wb_adr_o     = adr_q;
    assign wb_sel_o     = '1;
    assign fifo_dat_o   = mem_q[rd_ptr_q];
    assign fifo_empty_o = (level_q == '0);
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_wb_line_fetch.sv
// tb/tb_wb_line_fetch.sv - scoreboard bench for wb_line_fetch with a fixed-latency Wishbone slave
module tb_wb_line_fetch;

    localparam int AW    = 24;
    localparam int DW    = 16;
    localparam int LENW  = 10;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   base = '0;
    logic [LENW-1:0] len = '0;
    logic            busy, done, err, cyc, stb, we;
    logic [AW-1:0]   adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   wdat = '0;
    logic            ack = 1'b0;
    logic            rd = 1'b0;
    logic [DW-1:0]   fdat;
    logic            empty;
    logic [4:0]      level;

    wb_line_fetch #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .LEN_WIDTH     (LENW),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start_i     (start),
        .base_adr_i  (base),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .wb_cyc_o    (cyc),
        .wb_stb_o    (stb),
        .wb_we_o     (we),
        .wb_adr_o    (adr),
        .wb_sel_o    (sel),
        .wb_dat_i    (wdat),
        .wb_ack_i    (ack),
        .fifo_rd_i   (rd),
        .fifo_dat_o  (fdat),
        .fifo_empty_o(empty),
        .fifo_level_o(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [AW-1:0] exp_adr[$];
    logic [DW-1:0] exp_dat[$];

    int lat        = 3;
    bit ack_en     = 1'b1;
    int cnt        = 0;
    int reads      = 0;
    int done_cnt   = 0;
    int stb_cycles = 0;

    // Slave: checks each new request address, acks after lat strobe cycles with data = adr[15:0].
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (stb) stb_cycles++;
        if (!(cyc && stb)) begin
            ack = 1'b0;
            cnt = 0;
        end else if (!ack) begin
            if (cnt == 0) begin
                if (exp_adr.size() == 0) check_eq("wb_req_expected", 32'(exp_adr.size()), 32'd1);
                else check_eq("wb_adr", 32'(adr), 32'(exp_adr.pop_front()));
            end
            cnt++;
            if (ack_en && cnt >= lat) begin
                ack   = 1'b1;
                wdat  = adr[15:0];
                reads++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input logic [LENW-1:0] n, input bit accept);
        @(negedge clk);
        start = 1'b1;
        base  = b;
        len   = n;
        if (accept) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_adr.push_back(AW'(b + AW'(i)));
                exp_dat.push_back(DW'(b + AW'(i)));
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 32'(seen), 32'd1);
        if (seen) check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        check_eq({tag, "_nonempty"}, 32'(empty), 32'd0);
        if (!empty && exp_dat.size() > 0) check_eq(tag, 32'(fdat), 32'(exp_dat.pop_front()));
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) pop_one(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        int s0;
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_cyc", 32'(cyc), 32'd0);
        check_eq("rst_stb", 32'(stb), 32'd0);
        check_eq("rst_adr", 32'(adr), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_we", 32'(we), 32'd0);
        check_eq("rst_sel", 32'(sel), 32'h3);

        // Basic 4-word fetch with latency and throughput checks on the first word.
        r0 = reads;
        d0 = done_cnt;
        start_xfer(24'h000100, 10'd4, 1'b1);
        check_eq("t1_cyc_lat", 32'(cyc), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_adr0", 32'(adr), 32'h100);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        check_eq("t1_ack_seen", 32'(seen), 32'd1);
        check_eq("t1_empty_after_ack", 32'(empty), 32'd0);
        check_eq("t1_level_after_ack", 32'(level), 32'd1);
        check_eq("t1_gap_stb", 32'(stb), 32'd0);
        tick();
        check_eq("t1_next_stb", 32'(stb), 32'd1);
        check_eq("t1_adr1", 32'(adr), 32'h101);
        wait_done(200, "t1_done");
        repeat (2) @(negedge clk);
        check_eq("t1_reads", 32'(reads - r0), 32'd4);
        check_eq("t1_level", 32'(level), 32'd4);
        check_eq("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        drain(4, "t1_data");
        check_eq("t1_empty_end", 32'(empty), 32'd1);
        @(negedge clk);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check_eq("t1_pop_empty_level", 32'(level), 32'd0);
        check_eq("t1_pop_empty_flag", 32'(empty), 32'd1);

        // 20 words into a 16-deep FIFO: stall at full, ignored start while busy, resume on pops.
        r0 = reads;
        d0 = done_cnt;
        start_xfer(24'h000200, 10'd20, 1'b1);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (level == 5'd16) break;
        end
        repeat (30) @(negedge clk);
        check_eq("t2_reads_full", 32'(reads - r0), 32'd16);
        check_eq("t2_level_full", 32'(level), 32'd16);
        check_eq("t2_stb_full", 32'(stb), 32'd0);
        check_eq("t2_busy_full", 32'(busy), 32'd1);
        start_xfer(24'h000999, 10'd5, 1'b0);
        check_eq("t2_busy_ign", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        check_eq("t2_reads_ign", 32'(reads - r0), 32'd16);
        drain(4, "t2_pop");
        wait_done(300, "t2_done");
        repeat (2) @(negedge clk);
        check_eq("t2_reads_total", 32'(reads - r0), 32'd20);
        check_eq("t2_level_end", 32'(level), 32'd16);
        check_eq("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
        drain(16, "t2_data");

        // Zero-length start: no bus cycle, immediate done pulse.
        d0 = done_cnt;
        s0 = stb_cycles;
        start_xfer(24'h000000, 10'd0, 1'b1);
        check_eq("t3_done", 32'(done), 32'd1);
        check_eq("t3_busy", 32'(busy), 32'd0);
        check_eq("t3_cyc", 32'(cyc), 32'd0);
        check_eq("t3_err", 32'(err), 32'd0);
        tick();
        check_eq("t3_done_end", 32'(done), 32'd0);
        check_eq("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_eq("t3_no_stb", 32'(stb_cycles - s0), 32'd0);

        // Address wrap at the top of the address space.
        start_xfer(24'hFFFFFE, 10'd3, 1'b1);
        wait_done(200, "t4_done");
        tick();
        check_eq("t4_level", 32'(level), 32'd3);
        check_eq("t4_adr_wrapped", 32'(adr), 32'h000001);
        drain(3, "t4_data");

        // Reset while a strobe is active, with a word already in the FIFO.
        start_xfer(24'h000300, 10'd8, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (stb && level != 5'd0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t6_stb_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        d0  = done_cnt;
        tick();
        check_eq("t6_cyc", 32'(cyc), 32'd0);
        check_eq("t6_stb", 32'(stb), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_empty", 32'(empty), 32'd1);
        check_eq("t6_level", 32'(level), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_adr.delete();
        exp_dat.delete();
        repeat (5) @(negedge clk);
        check_eq("t6_no_done", 32'(done_cnt - d0), 32'd0);
        start_xfer(24'h000400, 10'd2, 1'b1);
        wait_done(200, "t6_post_done");
        drain(2, "t6_post_data");

`ifdef WB_FETCH_TIMEOUT_EN
        // Slave never acks: watchdog ends the transfer after 255 strobe cycles.
        ack_en = 1'b0;
        exp_adr.push_back(24'h000500);
        start_xfer(24'h000500, 10'd2, 1'b0);
        s0 = stb_cycles;
        seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!cyc) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t5_cyc_drop", 32'(seen), 32'd1);
        check_eq("t5_stb_cycles", 32'(stb_cycles - s0), 32'd255);
        check_eq("t5_err", 32'(err), 32'd1);
        check_eq("t5_done", 32'(done), 32'd1);
        ack_en = 1'b1;
        start_xfer(24'h000600, 10'd1, 1'b1);
        check_eq("t5_err_clr", 32'(err), 32'd0);
        wait_done(200, "t5_post_done");
        drain(1, "t5_post_data");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
